// File: rtl/ex_div_if.sv
// Pipeline-side handshake for the EX-stage divider: operands/control from EX,
// results and stall request back to the pipeline.
interface ex_div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_div;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             flush;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             done;
   logic             stallreq;

   modport master (
      output start, signed_div, dividend, divisor, flush,
      input  quotient, remainder, done, stallreq
   );

   modport slave (
      input  start, signed_div, dividend, divisor, flush,
      output quotient, remainder, done, stallreq
   );
endinterface

// File: rtl/ex_div.sv
// Multi-cycle radix-2 restoring divider for div.w/div.wu/mod.w/mod.wu in EX.
// state     | meaning
// S_IDLE    | waiting for start; latches operands
// S_DIVZERO | divisor was zero; one cycle before result
// S_ON      | one restoring iteration per cycle, cnt 0..WIDTH-1
// S_END     | done pulse, results valid, back to idle
module ex_div #(
   parameter int WIDTH = 32
) (
   input logic   clk,
   input logic   rst,
   ex_div_if.slave bus
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_DIVZERO = 2'd1;
   localparam logic [1:0] S_ON      = 2'd2;
   localparam logic [1:0] S_END     = 2'd3;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [2*WIDTH:0] work;
   logic [2*WIDTH:0] work_sh;
   logic [2*WIDTH:0] work_nxt;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] dvd_abs;
   logic [WIDTH-1:0] dsr_abs;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             done_q;
   logic             q_neg;
   logic             r_neg;

   always_comb begin
      dvd_abs  = (bus.signed_div && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
      dsr_abs  = (bus.signed_div && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
      work_sh  = work << 1;
      // upper half is always below 2*dsr, so bit WIDTH of the difference is its sign
      trial    = work_sh[2*WIDTH:WIDTH] - {1'b0, dsr};
      work_nxt = work_sh;
      if (!trial[WIDTH]) begin
         work_nxt[2*WIDTH:WIDTH] = trial;
         work_nxt[0]             = 1'b1;
      end
      q_fin = q_neg ? -work_nxt[WIDTH-1:0]       : work_nxt[WIDTH-1:0];
      r_fin = r_neg ? -work_nxt[2*WIDTH-1:WIDTH] : work_nxt[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         work        <= '0;
         dsr         <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (bus.start) begin
                     cnt <= '0;
                     if (bus.divisor == '0) begin
                        state <= S_DIVZERO;
                        work  <= {{(WIDTH+1){1'b0}}, bus.dividend};
                     end else begin
                        state <= S_ON;
                        work  <= {{(WIDTH+1){1'b0}}, dvd_abs};
                        dsr   <= dsr_abs;
                        q_neg <= bus.signed_div & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
                        r_neg <= bus.signed_div & bus.dividend[WIDTH-1];
                     end
                  end
               end
               S_DIVZERO: begin
                  state       <= S_END;
                  done_q      <= 1'b1;
                  quotient_q  <= '1;
                  remainder_q <= work[WIDTH-1:0];
               end
               S_ON: begin
                  work <= work_nxt;
                  cnt  <= cnt + 1'b1;
                  if (cnt == CW'(WIDTH-1)) begin
                     state       <= S_END;
                     done_q      <= 1'b1;
                     quotient_q  <= q_fin;
                     remainder_q <= r_fin;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.quotient  = quotient_q;
   assign bus.remainder = remainder_q;
   assign bus.done      = done_q;
   assign bus.stallreq  = rst & ~bus.flush &
                          (((state == S_IDLE) & bus.start) | (state == S_DIVZERO) | (state == S_ON));
endmodule
